axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 114 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging N AXI-Stream requesters onto one sink.
// The grant is held per packet; arbitration happens in IDLE and the search
// starts just after the previous packet's owner.
module axis_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_tvalid,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic [N-1:0]    s_tready,
    output logic            m_tvalid,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic [N-1:0]    grant,
    output logic [15:0]     pkt_cnt
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_id_q, last_id_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;

    logic            found;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;

    // Cyclic search for the first valid requester after last_id.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last_id_q) + i) % N);
            if (!found && s_tvalid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Sink/source muxing: only the owner is connected, and only in XFER.
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        if (state_q == XFER) begin
            m_tvalid          = s_tvalid[owner_q];
            m_tdata           = s_tdata[owner_q*DW +: DW];
            m_tlast           = s_tlast[owner_q];
            s_tready[owner_q] = m_tready;
        end
    end

    // Next-state: grant on arbitration, release on a transferred tlast beat.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_id_d = last_id_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = XFER;
                    owner_d = sel;
                    grant_d = N'(1) << sel;
                end
            end
            XFER: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = owner_q;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves last_id at N-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_id_q <= IW'(N - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_id_q <= last_id_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (N=4, DW=8) with hand-computed expectations.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    s_tvalid;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic [15:0]     pkt_cnt;

    int n_total;
    int n_bad;

    axis_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .grant    (grant),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks happen off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] d, input logic last);
        s_tdata[idx*DW +: DW] = d;
        s_tlast[idx]          = last;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [7:0] beats [4];
        int idx;
        int cyc;
        logic rdy;

        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_pkt", 32'(pkt_cnt), 32'h0);
        check("rst_mvalid", 32'(m_tvalid), 32'h0);
        check("rst_ready", 32'(s_tready), 32'h0);

        // Requesters 0 and 2, 3-beat packets each.
        m_tready = 1'b1;
        s_tvalid = 4'b0101;
        set_req(0, 8'hA0, 1'b0);
        set_req(2, 8'hC0, 1'b0);
        settle();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_mvalid", 32'(m_tvalid), 32'h0);
        check("idle_ready", 32'(s_tready), 32'h0);
        tick();
        check("p0_grant", 32'(grant), 32'b0001);
        for (int b = 0; b < 3; b++) begin
            set_req(0, 8'(8'hA0 + b), b == 2);
            settle();
            check("p0_data", 32'(m_tdata), 32'(8'hA0 + b));
            check("p0_last", 32'(m_tlast), 32'(b == 2));
            check("p0_ready", 32'(s_tready), 32'b0001);
            tick();
        end
        s_tvalid = 4'b0100;
        settle();
        check("bubble_grant", 32'(grant), 32'h0);
        check("bubble_mvalid", 32'(m_tvalid), 32'h0);
        check("p0_pkt", 32'(pkt_cnt), 32'd1);
        tick();
        check("p2_grant", 32'(grant), 32'b0100);
        for (int b = 0; b < 3; b++) begin
            set_req(2, 8'(8'hC0 + b), b == 2);
            settle();
            check("p2_data", 32'(m_tdata), 32'(8'hC0 + b));
            tick();
        end
        s_tvalid = '0;
        settle();
        check("p2_pkt", 32'(pkt_cnt), 32'd2);
        check("p2_grant_rel", 32'(grant), 32'h0);

        // All four continuously valid, single-beat packets, from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_tvalid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            settle();
            check("rr_gap_grant", 32'(grant), 32'h0);
            check("rr_gap_mvalid", 32'(m_tvalid), 32'h0);
            tick();
            check("rr_grant", 32'(grant), 32'(1 << (k % N)));
            check("rr_data", 32'(m_tdata), 32'(8'h10 + (k % N)));
            tick();
        end
        s_tvalid = '0;
        settle();
        check("rr_pkt", 32'(pkt_cnt), 32'd6);

        // Owner 1 stalls two cycles while requester 3 waits.
        s_tvalid = 4'b0010;
        set_req(1, 8'h51, 1'b0);
        tick();
        check("st_grant", 32'(grant), 32'b0010);
        s_tvalid = 4'b1010;
        set_req(3, 8'h73, 1'b1);
        settle();
        check("st_b0", 32'(m_tdata), 32'h51);
        tick();
        s_tvalid = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("st_hole_mvalid", 32'(m_tvalid), 32'h0);
            check("st_hole_grant", 32'(grant), 32'b0010);
            tick();
        end
        s_tvalid = 4'b1010;
        set_req(1, 8'h52, 1'b1);
        settle();
        check("st_b1_mvalid", 32'(m_tvalid), 32'h1);
        check("st_b1", 32'(m_tdata), 32'h52);
        tick();
        check("st_rel", 32'(grant), 32'h0);
        check("st_pkt", 32'(pkt_cnt), 32'd7);
        tick();
        check("st_g3", 32'(grant), 32'b1000);
        check("st_g3_data", 32'(m_tdata), 32'h73);
        tick();
        s_tvalid = '0;
        settle();
        check("st_pkt3", 32'(pkt_cnt), 32'd8);

        // m_tready toggling during a 4-beat packet from requester 0.
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        s_tvalid = 4'b0001;
        set_req(0, beats[0], 1'b0);
        tick();
        check("bp_grant", 32'(grant), 32'b0001);
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            rdy = (cyc % 2) == 0;
            m_tready = rdy;
            set_req(0, beats[idx], idx == 3);
            settle();
            check("bp_data", 32'(m_tdata), 32'(beats[idx]));
            check("bp_ready", 32'(s_tready), 32'(rdy));
            check("bp_pkt_hold", 32'(pkt_cnt), 32'd8);
            tick();
            if (rdy) idx++;
            cyc++;
        end
        check("bp_cycles", 32'(cyc), 32'd7);
        s_tvalid = '0;
        m_tready = 1'b1;
        settle();
        check("bp_pkt", 32'(pkt_cnt), 32'd9);
        check("bp_rel", 32'(grant), 32'h0);

        // Reset mid-packet; next search restarts at requester 0.
        s_tvalid = 4'b0010;
        set_req(1, 8'h61, 1'b0);
        tick();
        check("ab_grant", 32'(grant), 32'b0010);
        tick();
        set_req(1, 8'h62, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_tvalid = 4'b0011;
        set_req(0, 8'h01, 1'b1);
        settle();
        check("ab_pkt", 32'(pkt_cnt), 32'h0);
        check("ab_grant0", 32'(grant), 32'h0);
        check("ab_ready", 32'(s_tready), 32'h0);
        check("ab_mvalid", 32'(m_tvalid), 32'h0);
        tick();
        check("ab_regrant", 32'(grant), 32'b0001);
        s_tvalid = 4'b0001;
        tick();
        s_tvalid = '0;
        settle();
        check("ab_pkt1", 32'(pkt_cnt), 32'd1);

        // Counter wrap: preload 0xFFFF, complete one packet.
        force dut.pkt_cnt_q = 16'hFFFF;
        tick();
        release dut.pkt_cnt_q;
        settle();
        check("wr_pre", 32'(pkt_cnt), 32'hFFFF);
        s_tvalid = 4'b0100;
        set_req(2, 8'h99, 1'b1);
        tick();
        check("wr_grant", 32'(grant), 32'b0100);
        tick();
        s_tvalid = '0;
        settle();
        check("wr_pkt", 32'(pkt_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
